jackpot_round_ctrl: RTL and testbench
=====================================

JACKPOT_ROUND_CTRL -- requirements
Module: jackpot_round_ctrl

Interface
REQ-001 SHALL have parameter: DIV_BASE, 2, base clock cycles per LED step; step period = DIV_BASE*(4-level) cycles.
REQ-002 SHALL have parameter: HOLD_CYC, 8, cycles the WIN or MISS display is held.
REQ-003 SHALL have port: clock  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  asynchronous push-button; each rising edge toggles the game between idle and spinning.
REQ-006 SHALL have port: SWITCHES  input  4  asynchronous player switches.
REQ-007 SHALL have port: LEDS  output  4  LED pattern: one-hot while spinning, 1111 on win, 0000 when idle or on a miss.
REQ-008 SHALL have port: level  output  2  speed level, 0 (slowest) to 3 (fastest).
REQ-009 SHALL have port: score  output  8  count of wins, saturating.
REQ-010 SHALL have port: win_pulse  output  1  single-cycle strobe on entry to WIN.

Function
REQ-011 SHALL pass start and SWITCHES through a 2-flop synchronizer, then a rising-edge detector; a detected edge is visible to the FSM exactly 3 clock edges after the input changes.
REQ-012 SHALL implement FSM states IDLE, SPIN, WIN and MISS.
REQ-013 IDLE SHALL drive LEDS=0000; a start edge SHALL enter SPIN with LEDS=0001 and the step counter cleared.
REQ-014 SPIN SHALL rotate LEDS 0001->0010->0100->1000->0001, advancing once per step period, and SHALL wrap from 1000 to 0001.
REQ-015 A start edge in SPIN SHALL return to IDLE; score and level SHALL be retained.
REQ-016 In SPIN, a switch-edge vector equal to the current LEDS SHALL enter WIN; win_pulse=1 for that cycle, score+1 saturating at 255, level+1 saturating at 3.
REQ-017 In SPIN, any other nonzero switch-edge vector, including a multi-bit vector that contains the lit bit, SHALL enter MISS with level cleared to 0 and score unchanged.
REQ-018 When a switch edge and a step tick fall on the same cycle, the match SHALL use the pre-advance LEDS and the advance SHALL be suppressed.
REQ-019 When a start edge and a switch edge fall on the same cycle in SPIN, start SHALL win: go to IDLE and ignore the switch edge.
REQ-020 WIN SHALL drive LEDS=1111 and MISS SHALL drive LEDS=0000, each for exactly HOLD_CYC cycles.
REQ-021 After the hold, the FSM SHALL re-enter SPIN with LEDS=0001, the counter cleared, and the new level's period applied.
REQ-022 Switch edges SHALL be ignored in IDLE, WIN and MISS; start edges SHALL be ignored in WIN and MISS.
REQ-023 A held or bouncing-high switch SHALL produce no further edge until it returns to 0.

Reset
REQ-024 While reset=0, the block SHALL asynchronously force: state=IDLE, LEDS=0000, level=0, score=0, win_pulse=0, synchronizer and edge flops=0, counters=0.
REQ-025 Reset asserted mid-SPIN, WIN or MISS SHALL abort immediately with no residual pulse after release.
REQ-026 After reset release, the block SHALL stay in IDLE until a start edge occurs.

Structure
REQ-027 The state encoding, LED constants (LED_OFF=0000, LED_ALL=1111, LED_FIRST=0001) and level width SHALL be placed in a shared package, jackpot_pkg.
REQ-028 The synchronizer and edge detector SHALL be a parameterized-width sub-module, sync_edge, instantiated for start (width 1) and SWITCHES (width 4).
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Reset, then start edge -> LEDS=0001, then 0010 after 8 cycles, then 0100 after 8 more (level 0, DIV_BASE=2).
REQ-031 SWITCHES=0010 while LEDS=0010 -> win_pulse for 1 cycle, LEDS=1111 for 8 cycles, score=1, level=1, then SPIN at a 6-cycle period.
REQ-032 SWITCHES=0100 while LEDS=0001 at level 2 -> LEDS=0000 for 8 cycles, level=0, score unchanged.
REQ-033 SWITCHES 0000->0011 while LEDS=0001 -> MISS; 256 wins -> score stays 255; 4 wins -> level stays 3 with a 2-cycle period.
REQ-034 reset=0 asserted mid-WIN -> LEDS=0000, score=0, level=0 within the same cycle; after release, start is required to spin.
REQ-035 start edge coincident with a matching switch edge -> IDLE, no win_pulse, score unchanged.

Source files
------------

// File: rtl/jackpot_pkg.sv
// Shared types and constants for the jackpot round controller.
package jackpot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_WIN  = 2'd2,
    ST_MISS = 2'd3
  } state_t;

  localparam int LEVEL_W = 2;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  localparam logic [3:0] LED_OFF   = 4'b0000;
  localparam logic [3:0] LED_ALL   = 4'b1111;
  localparam logic [3:0] LED_FIRST = 4'b0001;

  localparam logic [7:0] SCORE_MAX = 8'hFF;

  function automatic logic [3:0] rotate_led(input logic [3:0] led);
    return {led[2:0], led[3]};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A rising input is reported on rise three clock edges after it changes.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;
  logic [W-1:0] rise_q;
  logic [W-1:0] rise_d;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign rise_d[gi] = sync_q[gi] & ~prev_q[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/jackpot_round_ctrl.sv
// Jackpot reaction game: a lit LED rotates, the player hits the matching switch.
// Wins raise the speed level and score; misses drop the level back to 0.
module jackpot_round_ctrl
  import jackpot_pkg::*;
#(
  parameter int DIV_BASE = 2,
  parameter int HOLD_CYC = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         SWITCHES,
  output logic [3:0]         LEDS,
  output logic [LEVEL_W-1:0] level,
  output logic [7:0]         score,
  output logic               win_pulse
);

  localparam int CNT_W  = $clog2(4 * DIV_BASE + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  logic       start_rise;
  logic [3:0] sw_rise;

  sync_edge #(.W(1)) u_start_edge (
    .clock (clock),
    .reset (reset),
    .din   (start),
    .rise  (start_rise)
  );

  sync_edge #(.W(4)) u_sw_edge (
    .clock (clock),
    .reset (reset),
    .din   (SWITCHES),
    .rise  (sw_rise)
  );

  state_t             state_q, state_d;
  logic [3:0]         leds_q, leds_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [7:0]         score_q, score_d;
  logic               win_q, win_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   step_last;

  // Faster levels shorten the step period: DIV_BASE * (4 - level) cycles.
  assign step_last = CNT_W'(DIV_BASE * (4 - int'(level_q)) - 1);

  always_comb begin
    state_d    = state_q;
    leds_d     = leds_q;
    level_d    = level_q;
    score_d    = score_q;
    win_d      = 1'b0;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        leds_d = LED_OFF;
        if (start_rise) begin
          state_d    = ST_SPIN;
          leds_d     = LED_FIRST;
          step_cnt_d = '0;
        end
      end
      ST_SPIN: begin
        // Start beats a switch hit; a hit beats the step advance so the
        // player is judged against the LED they actually saw.
        if (start_rise) begin
          state_d = ST_IDLE;
          leds_d  = LED_OFF;
        end else if (sw_rise != 4'b0000) begin
          hold_cnt_d = '0;
          if (sw_rise == leds_q) begin
            state_d = ST_WIN;
            leds_d  = LED_ALL;
            win_d   = 1'b1;
            if (score_q != SCORE_MAX) score_d = score_q + 8'd1;
            if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
          end else begin
            state_d = ST_MISS;
            leds_d  = LED_OFF;
            level_d = '0;
          end
        end else if (step_cnt_q == step_last) begin
          step_cnt_d = '0;
          leds_d     = rotate_led(leds_q);
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end
      ST_WIN, ST_MISS: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_SPIN;
          leds_d     = LED_FIRST;
          step_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        leds_d  = LED_OFF;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      leds_q     <= LED_OFF;
      level_q    <= '0;
      score_q    <= '0;
      win_q      <= 1'b0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      leds_q     <= leds_d;
      level_q    <= level_d;
      score_q    <= score_d;
      win_q      <= win_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign LEDS      = leds_q;
  assign level     = level_q;
  assign score     = score_q;
  assign win_pulse = win_q;

endmodule

// File: tb/tb_jackpot_round_ctrl.sv
// Directed bench for jackpot_round_ctrl; input edges act 4 clock edges after being driven.
module tb_jackpot_round_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] SWITCHES = 4'b0000;
  logic [3:0] LEDS;
  logic [1:0] level;
  logic [7:0] score;
  logic       win_pulse;

  int checks = 0;
  int errors = 0;

  jackpot_round_ctrl #(.DIV_BASE(2), .HOLD_CYC(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .SWITCHES  (SWITCHES),
    .LEDS      (LEDS),
    .level     (level),
    .score     (score),
    .win_pulse (win_pulse)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the DUT freshly spinning at level 0: LEDS=0001, step counter 0.
  task automatic begin_spin();
    reset = 1'b0; start = 1'b0; SWITCHES = 4'b0000;
    step(2);
    reset = 1'b1;
    step(1);
    start = 1'b1;
    step(4);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; SWITCHES = 4'b0000;
    step(2);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL reset_leds LEDS=%b expected 0000", LEDS); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level level=%0d expected 0", level); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score score=%0d expected 0", score); end
    checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL reset_win_pulse win_pulse=%b expected 0", win_pulse); end
    reset = 1'b1;
    step(10);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL reset_stays_idle LEDS=%b expected 0000", LEDS); end
    $display("reset: LEDS=%b level=%0d score=%0d", LEDS, level, score);
  endtask

  task automatic test_spin();
    begin_spin();
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL spin_first LEDS=%b expected 0001", LEDS); end
    step(7);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL spin_hold7 LEDS=%b expected 0001", LEDS); end
    step(1);
    checks++; if (LEDS !== 4'b0010) begin errors++; $display("FAIL spin_step1 LEDS=%b expected 0010", LEDS); end
    step(8);
    checks++; if (LEDS !== 4'b0100) begin errors++; $display("FAIL spin_step2 LEDS=%b expected 0100", LEDS); end
    step(8);
    checks++; if (LEDS !== 4'b1000) begin errors++; $display("FAIL spin_step3 LEDS=%b expected 1000", LEDS); end
    step(8);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL spin_wrap LEDS=%b expected 0001", LEDS); end
    $display("spin: rotated to 1000 and wrapped to LEDS=%b", LEDS);
  endtask

  task automatic test_win();
    begin_spin();
    step(8);
    checks++; if (LEDS !== 4'b0010) begin errors++; $display("FAIL win_pre_leds LEDS=%b expected 0010", LEDS); end
    SWITCHES = 4'b0010;
    step(3);
    checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL win_early win_pulse=%b expected 0", win_pulse); end
    step(1);
    checks++; if (win_pulse !== 1'b1) begin errors++; $display("FAIL win_pulse win_pulse=%b expected 1", win_pulse); end
    checks++; if (LEDS !== 4'b1111) begin errors++; $display("FAIL win_leds LEDS=%b expected 1111", LEDS); end
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL win_score score=%0d expected 1", score); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL win_level level=%0d expected 1", level); end
    step(1);
    SWITCHES = 4'b0000;
    checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL win_pulse_width win_pulse=%b expected 0", win_pulse); end
    step(6);
    checks++; if (LEDS !== 4'b1111) begin errors++; $display("FAIL win_hold_last LEDS=%b expected 1111", LEDS); end
    step(1);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL win_resume LEDS=%b expected 0001", LEDS); end
    step(5);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL win_l1_hold LEDS=%b expected 0001", LEDS); end
    step(1);
    checks++; if (LEDS !== 4'b0010) begin errors++; $display("FAIL win_l1_period LEDS=%b expected 0010", LEDS); end
    $display("win: score=%0d level=%0d LEDS=%b", score, level, LEDS);
  endtask

  task automatic test_miss();
    begin_spin();
    SWITCHES = 4'b0001;
    step(4);
    step(1); SWITCHES = 4'b0000;
    step(4); SWITCHES = 4'b0001;
    step(4);
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL miss_setup_level level=%0d expected 2", level); end
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL miss_setup_score score=%0d expected 2", score); end
    step(1); SWITCHES = 4'b0000;
    step(6); SWITCHES = 4'b0100;
    step(4);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL miss_leds LEDS=%b expected 0000", LEDS); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL miss_level level=%0d expected 0", level); end
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL miss_score score=%0d expected 2", score); end
    checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL miss_win_pulse win_pulse=%b expected 0", win_pulse); end
    step(1); SWITCHES = 4'b0000;
    step(6);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL miss_hold_last LEDS=%b expected 0000", LEDS); end
    step(1);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL miss_resume LEDS=%b expected 0001", LEDS); end
    $display("miss: level=%0d score=%0d LEDS=%b", level, score, LEDS);
    // Switch hit lands on the same edge as the step tick.
    step(4); SWITCHES = 4'b0001;
    step(4);
    checks++; if (LEDS !== 4'b1111) begin errors++; $display("FAIL tick_hit_leds LEDS=%b expected 1111", LEDS); end
    checks++; if (win_pulse !== 1'b1) begin errors++; $display("FAIL tick_hit_pulse win_pulse=%b expected 1", win_pulse); end
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL tick_hit_score score=%0d expected 3", score); end
    step(1); SWITCHES = 4'b0000;
    step(7);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL multi_pre LEDS=%b expected 0001", LEDS); end
    SWITCHES = 4'b0011;
    step(4);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL multi_leds LEDS=%b expected 0000", LEDS); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL multi_level level=%0d expected 0", level); end
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL multi_score score=%0d expected 3", score); end
    step(2); SWITCHES = 4'b0111;
    step(6);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL miss_ignore_sw LEDS=%b expected 0001", LEDS); end
    step(4);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL held_sw LEDS=%b expected 0001", LEDS); end
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL held_sw_score score=%0d expected 3", score); end
    SWITCHES = 4'b0000;
    $display("multi/held: LEDS=%b level=%0d score=%0d", LEDS, level, score);
  endtask

  task automatic test_start_paths();
    begin_spin();
    SWITCHES = 4'b0001;
    step(4);
    step(1); SWITCHES = 4'b0000; start = 1'b1;
    step(1); start = 1'b0;
    step(3);
    checks++; if (LEDS !== 4'b1111) begin errors++; $display("FAIL win_ignore_start LEDS=%b expected 1111", LEDS); end
    step(3);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL win_start_resume LEDS=%b expected 0001", LEDS); end
    start = 1'b1; SWITCHES = 4'b0001;
    step(4);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL start_vs_sw_leds LEDS=%b expected 0000", LEDS); end
    checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL start_vs_sw_pulse win_pulse=%b expected 0", win_pulse); end
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL start_vs_sw_score score=%0d expected 1", score); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL start_vs_sw_level level=%0d expected 1", level); end
    step(1); start = 1'b0; SWITCHES = 4'b0010;
    checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL start_vs_sw_late win_pulse=%b expected 0", win_pulse); end
    step(7);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL idle_ignore_sw LEDS=%b expected 0000", LEDS); end
    SWITCHES = 4'b0000; start = 1'b1;
    step(4);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL restart_leds LEDS=%b expected 0001", LEDS); end
    start = 1'b0;
    step(2); start = 1'b1;
    step(3);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL stop_pre LEDS=%b expected 0001", LEDS); end
    step(1);
    start = 1'b0;
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL stop_leds LEDS=%b expected 0000", LEDS); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL stop_level level=%0d expected 1", level); end
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL stop_score score=%0d expected 1", score); end
    $display("start paths: LEDS=%b level=%0d score=%0d", LEDS, level, score);
  endtask

  task automatic test_saturation();
    logic [7:0] exp_score;
    logic [1:0] exp_level;
    begin_spin();
    SWITCHES = 4'b0001;
    step(4);
    for (int i = 1; i <= 258; i++) begin
      exp_score = (i > 255) ? 8'd255 : 8'(i);
      exp_level = (i > 3) ? 2'd3 : 2'(i);
      checks++; if (win_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse win %0d win_pulse=%b expected 1", i, win_pulse); end
      checks++; if (score !== exp_score) begin errors++; $display("FAIL sat_score win %0d score=%0d expected %0d", i, score, exp_score); end
      checks++; if (level !== exp_level) begin errors++; $display("FAIL sat_level win %0d level=%0d expected %0d", i, level, exp_level); end
      step(1); SWITCHES = 4'b0000;
      if (i < 258) begin
        step(4); SWITCHES = 4'b0001;
        step(4);
      end
    end
    $display("saturation: score=%0d level=%0d", score, level);
    step(7);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL l3_resume LEDS=%b expected 0001", LEDS); end
    step(1);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL l3_hold LEDS=%b expected 0001", LEDS); end
    step(1);
    checks++; if (LEDS !== 4'b0010) begin errors++; $display("FAIL l3_period LEDS=%b expected 0010", LEDS); end
    $display("level 3 period: LEDS=%b", LEDS);
  endtask

  task automatic test_reset_mid_win();
    begin_spin();
    SWITCHES = 4'b0001;
    step(4);
    checks++; if (win_pulse !== 1'b1) begin errors++; $display("FAIL rst_win_setup win_pulse=%b expected 1", win_pulse); end
    reset = 1'b0;
    #1;
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL rst_mid_leds LEDS=%b expected 0000", LEDS); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_mid_score score=%0d expected 0", score); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL rst_mid_level level=%0d expected 0", level); end
    checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse win_pulse=%b expected 0", win_pulse); end
    SWITCHES = 4'b0000;
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL rst_after_leds cycle %0d LEDS=%b expected 0000", i, LEDS); end
      checks++; if (win_pulse !== 1'b0) begin errors++; $display("FAIL rst_after_pulse cycle %0d win_pulse=%b expected 0", i, win_pulse); end
    end
    $display("reset mid-WIN: LEDS=%b score=%0d level=%0d", LEDS, score, level);
  endtask

  initial begin
    test_reset();
    test_spin();
    test_win();
    test_miss();
    test_start_paths();
    test_saturation();
    test_reset_mid_win();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
